rom_loader: RTL and testbench

//  Bridges hps_io ROM download bytes (ioctl_index==0) to SDRAM port 0 as 16-bit word writes.

---
 rtl/m72_pkg.sv | 13 +
 rtl/rom_loader_if.sv | 28 ++
 rtl/rom_loader.sv | 164 ++++++++++++++++
 tb/tb_rom_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/m72_pkg.sv
// Shared types and constants for the ROM download bridge (rom_loader).
package m72_pkg;

  typedef enum logic [1:0] {
    RESYNC,
    IDLE,
    HAVE_LO,
    WAIT_ACK
  } loader_state_t;

  localparam logic [7:0] ROM_INDEX_DEFAULT = 8'd0;

endpackage

// File: rtl/rom_loader_if.sv
// hps_io download bus plus SDRAM port-0 write channel, grouped for rom_loader.
// slave: the loader's view. master: the hps_io/SDRAM environment's view.
interface rom_loader_if #(
  parameter int ADDR_W = 25
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic [ADDR_W-2:0] sdr_addr;
  logic [15:0]       sdr_din;
  logic              sdr_wrl;
  logic              sdr_wrh;
  logic              sdr_req;
  logic              sdr_ack;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
    output ioctl_wait, sdr_addr, sdr_din, sdr_wrl, sdr_wrh, sdr_req
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
    input  ioctl_wait, sdr_addr, sdr_din, sdr_wrl, sdr_wrh, sdr_req
  );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: packs hps_io ROM download bytes into 16-bit SDRAM word writes
// using the toggle req/ack handshake, stalling hps_io via ioctl_wait.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to add csum_out/csum_clr.
module rom_loader
  import m72_pkg::*;
#(
  parameter logic [7:0] ROM_INDEX = ROM_INDEX_DEFAULT,
  parameter int         ADDR_W    = 25,
  parameter int         TIMEOUT   = 1023
) (
  input  logic              clk_sys,
  input  logic              reset,
  rom_loader_if.slave       bus,
  output logic              busy,
  output logic              err
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       csum_out,
  input  logic              csum_clr
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  loader_state_t     state;
  logic              download_d;
  logic              rp_vld;      // replay slot: byte that arrived while a write was outstanding
  logic [ADDR_W-1:0] rp_addr;
  logic [7:0]        rp_data;
  logic [CNT_W-1:0]  tmo_cnt;

  logic              accept;
  logic              dl_rise;
  logic              ack_seen;
  logic              src_vld;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_data;

  assign accept   = bus.ioctl_wr && (bus.ioctl_index == ROM_INDEX);
  assign dl_rise  = bus.ioctl_download && !download_d;
  assign ack_seen = (bus.sdr_req == bus.sdr_ack);
  assign busy     = (state == HAVE_LO) || (state == WAIT_ACK);

  // Byte to start from when idle: a pending replay byte takes precedence over new input.
  always_comb begin
    src_vld  = accept;
    src_addr = bus.ioctl_addr;
    src_data = bus.ioctl_dout;
    if (rp_vld) begin
      src_vld  = 1'b1;
      src_addr = rp_addr;
      src_data = rp_data;
    end
  end

  // Loader FSM with all handshake outputs registered.
  // NOTE: later non-blocking assignments in the same cycle override earlier defaults.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state          <= RESYNC;
      download_d     <= 1'b0;
      rp_vld         <= 1'b0;
      rp_addr        <= '0;
      rp_data        <= '0;
      tmo_cnt        <= '0;
      err            <= 1'b0;
      bus.ioctl_wait <= 1'b0;
      bus.sdr_addr   <= '0;
      bus.sdr_din    <= '0;
      bus.sdr_wrl    <= 1'b0;
      bus.sdr_wrh    <= 1'b0;
      bus.sdr_req    <= 1'b0;
    end else begin
      download_d <= bus.ioctl_download;
      if (dl_rise) err <= 1'b0;

      case (state)
        // Adopt the controller's ack so an in-flight write is never re-issued.
        RESYNC: begin
          bus.sdr_req <= bus.sdr_ack;
          state       <= IDLE;
        end

        HAVE_LO: begin
          if (accept) begin
            bus.sdr_req    <= ~bus.sdr_req;
            bus.ioctl_wait <= 1'b1;
            tmo_cnt        <= '0;
            state          <= WAIT_ACK;
            if (bus.ioctl_addr[0] && (bus.ioctl_addr[ADDR_W-1:1] == bus.sdr_addr)) begin
              bus.sdr_din[15:8] <= bus.ioctl_dout;
              bus.sdr_wrl       <= 1'b1;
              bus.sdr_wrh       <= 1'b1;
            end else begin
              // Flush the held low byte; the new byte is replayed after the ack.
              bus.sdr_wrl <= 1'b1;
              bus.sdr_wrh <= 1'b0;
              rp_vld      <= 1'b1;
              rp_addr     <= bus.ioctl_addr;
              rp_data     <= bus.ioctl_dout;
            end
          end else if (!bus.ioctl_download) begin
            bus.sdr_wrl    <= 1'b1;
            bus.sdr_wrh    <= 1'b0;
            bus.sdr_req    <= ~bus.sdr_req;
            bus.ioctl_wait <= 1'b1;
            tmo_cnt        <= '0;
            state          <= WAIT_ACK;
          end
        end

        default: begin // IDLE, or WAIT_ACK
          if ((state == WAIT_ACK) && !ack_seen) begin
            if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
              err            <= 1'b1;
              bus.sdr_req    <= bus.sdr_ack;
              bus.ioctl_wait <= 1'b0;
              rp_vld         <= 1'b0;
              state          <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
              if (accept && !rp_vld) begin
                rp_vld  <= 1'b1;
                rp_addr <= bus.ioctl_addr;
                rp_data <= bus.ioctl_dout;
              end
            end
          end else begin
            rp_vld         <= 1'b0;
            bus.ioctl_wait <= 1'b0;
            state          <= IDLE;
            if (src_vld) begin
              bus.sdr_addr <= src_addr[ADDR_W-1:1];
              if (!src_addr[0]) begin
                bus.sdr_din[7:0] <= src_data;
                bus.sdr_wrl      <= 1'b1;
                bus.sdr_wrh      <= 1'b0;
                state            <= HAVE_LO;
              end else begin
                bus.sdr_din[15:8] <= src_data;
                bus.sdr_wrl       <= 1'b0;
                bus.sdr_wrh       <= 1'b1;
                bus.sdr_req       <= ~bus.sdr_req;
                bus.ioctl_wait    <= 1'b1;
                tmo_cnt           <= '0;
                state             <= WAIT_ACK;
              end
            end
          end
        end
      endcase
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  // Wrapping 16-bit sum of every accepted byte.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                  csum_out <= '0;
    else if (csum_clr || dl_rise) csum_out <= '0;
    else if (accept)            csum_out <= csum_out + {8'd0, bus.ioctl_dout};
  end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: SDRAM toggle responder, write monitor, scenario tasks.
module tb_rom_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic err;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] din;
    logic        wrl;
    logic        wrh;
  } wr_t;

  wr_t  wq[$];
  wr_t  w;
  logic ack_en = 1'b1;
  logic mon_en = 1'b1;
  logic prev_req = 1'b0;
  int   ack_dly = 0;

  always #5 clk = ~clk;

  rom_loader_if #(.ADDR_W(25)) bus ();

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] csum_out;
  rom_loader #(.TIMEOUT(16)) dut (
    .clk_sys(clk), .reset(rst), .bus(bus.slave), .busy(busy), .err(err),
    .csum_out(csum_out), .csum_clr(1'b0)
  );
`else
  rom_loader #(.TIMEOUT(16)) dut (
    .clk_sys(clk), .reset(rst), .bus(bus.slave), .busy(busy), .err(err)
  );
`endif

  // SDRAM model: acknowledges a toggled request three negedges later.
  initial begin
    bus.sdr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && (bus.sdr_req !== bus.sdr_ack)) begin
        if (ack_dly == 2) begin
          bus.sdr_ack = bus.sdr_req;
          ack_dly = 0;
        end else ack_dly++;
      end else ack_dly = 0;
    end
  end

  // Write monitor: every request toggle is logged with its payload.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mon_en && (bus.sdr_req !== prev_req))
        wq.push_back('{bus.sdr_addr, bus.sdr_din, bus.sdr_wrl, bus.sdr_wrh});
      prev_req = bus.sdr_req;
    end
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx);
    int n = 0;
    while (bus.ioctl_wait && n < 200) begin @(negedge clk); n++; end
    if (bus.ioctl_wait) begin tests++; fails++; $display("FAIL send_stall: ioctl_wait still 1 after %0d cycles", n); end
    bus.ioctl_index = idx;
    bus.ioctl_addr  = a;
    bus.ioctl_dout  = d;
    bus.ioctl_wr    = 1'b1;
    @(negedge clk);
    bus.ioctl_wr    = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.ioctl_wait && n < 200) begin @(negedge clk); n++; end
    tests++; if (bus.ioctl_wait !== 1'b0) begin fails++; $display("FAIL wait_release: ioctl_wait=%b after %0d cycles, want 0", bus.ioctl_wait, n); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (bus.ioctl_wait !== 1'b0) begin fails++; $display("FAIL rst_wait: got %b want 0", bus.ioctl_wait); end
    tests++; if (bus.sdr_addr !== 24'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", bus.sdr_addr); end
    tests++; if (bus.sdr_din !== 16'h0) begin fails++; $display("FAIL rst_din: got %h want 0", bus.sdr_din); end
    tests++; if ({bus.sdr_wrl, bus.sdr_wrh, bus.sdr_req} !== 3'b000) begin fails++; $display("FAIL rst_ctl: got %b want 000", {bus.sdr_wrl, bus.sdr_wrh, bus.sdr_req}); end
    tests++; if ({busy, err} !== 2'b00) begin fails++; $display("FAIL rst_status: got %b want 00", {busy, err}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (bus.sdr_req !== bus.sdr_ack) begin fails++; $display("FAIL rst_resync: req %b ack %b", bus.sdr_req, bus.sdr_ack); end
  endtask

  task automatic test_pair();
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'd0, 8'h11, 8'd0);
    tests++; if ({busy, bus.ioctl_wait} !== 2'b10) begin fails++; $display("FAIL pair_hold: busy/wait got %b want 10", {busy, bus.ioctl_wait}); end
    send_byte(25'd1, 8'h22, 8'd0);
    tests++; if (bus.ioctl_wait !== 1'b1) begin fails++; $display("FAIL pair_wait: got %b want 1", bus.ioctl_wait); end
    wait_idle();
    tests++; if (bus.sdr_req !== bus.sdr_ack) begin fails++; $display("FAIL pair_ack: req %b ack %b", bus.sdr_req, bus.sdr_ack); end
    tests++; if (wq.size() != 1) begin fails++; $display("FAIL pair_count: got %0d writes want 1", wq.size()); end
    else begin
      w = wq.pop_front();
      tests++; if ({w.addr, w.din, w.wrl, w.wrh} !== {24'd0, 16'h2211, 2'b11}) begin fails++; $display("FAIL pair_write: addr %h din %h wrl %b wrh %b, want 0 2211 1 1", w.addr, w.din, w.wrl, w.wrh); end
    end
  endtask

  task automatic test_odd_only();
    send_byte(25'd5, 8'hAA, 8'd0);
    wait_idle();
    tests++; if (wq.size() != 1) begin fails++; $display("FAIL odd_count: got %0d writes want 1", wq.size()); end
    else begin
      w = wq.pop_front();
      tests++; if ({w.addr, w.din[15:8], w.wrl, w.wrh} !== {24'd2, 8'hAA, 2'b01}) begin fails++; $display("FAIL odd_write: addr %h hi %h wrl %b wrh %b, want 2 aa 0 1", w.addr, w.din[15:8], w.wrl, w.wrh); end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL odd_busy: got %b want 0", busy); end
  endtask

  task automatic test_split_and_flush();
    send_byte(25'd8, 8'h33, 8'd0);
    tests++; if (bus.sdr_addr !== 24'd4) begin fails++; $display("FAIL split_hold_addr: got %h want 4", bus.sdr_addr); end
    send_byte(25'd12, 8'h44, 8'd0);
    tests++; if ({bus.ioctl_wait, bus.sdr_wrl, bus.sdr_wrh} !== 3'b110) begin fails++; $display("FAIL split_flush_ctl: got %b want 110", {bus.ioctl_wait, bus.sdr_wrl, bus.sdr_wrh}); end
    wait_idle();
    tests++; if (wq.size() != 1) begin fails++; $display("FAIL split_count: got %0d writes want 1", wq.size()); end
    else begin
      w = wq.pop_front();
      tests++; if ({w.addr, w.din[7:0], w.wrl, w.wrh} !== {24'd4, 8'h33, 2'b10}) begin fails++; $display("FAIL split_write: addr %h lo %h wrl %b wrh %b, want 4 33 1 0", w.addr, w.din[7:0], w.wrl, w.wrh); end
    end
    tests++; if ({busy, bus.sdr_addr, bus.sdr_din[7:0]} !== {1'b1, 24'd6, 8'h44}) begin fails++; $display("FAIL split_replay: busy %b addr %h lo %h, want 1 6 44", busy, bus.sdr_addr, bus.sdr_din[7:0]); end
    send_byte(25'd20, 8'h55, 8'd0);
    wait_idle();
    tests++; if (wq.size() != 1) begin fails++; $display("FAIL flush6_count: got %0d writes want 1", wq.size()); end
    else begin
      w = wq.pop_front();
      tests++; if ({w.addr, w.din[7:0], w.wrl, w.wrh} !== {24'd6, 8'h44, 2'b10}) begin fails++; $display("FAIL flush6_write: addr %h lo %h wrl %b wrh %b, want 6 44 1 0", w.addr, w.din[7:0], w.wrl, w.wrh); end
    end
    bus.ioctl_download = 1'b0;
    @(negedge clk);
    tests++; if (bus.ioctl_wait !== 1'b1) begin fails++; $display("FAIL end_flush_wait: got %b want 1", bus.ioctl_wait); end
    wait_idle();
    tests++; if (wq.size() != 1) begin fails++; $display("FAIL end_flush_count: got %0d writes want 1", wq.size()); end
    else begin
      w = wq.pop_front();
      tests++; if ({w.addr, w.din[7:0], w.wrl, w.wrh} !== {24'd10, 8'h55, 2'b10}) begin fails++; $display("FAIL end_flush_write: addr %h lo %h wrl %b wrh %b, want a 55 1 0", w.addr, w.din[7:0], w.wrl, w.wrh); end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL end_busy: got %b want 0", busy); end
  endtask

  task automatic test_other_index();
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'd41, 8'h99, 8'd1);
    repeat (5) @(negedge clk);
    tests++; if ({busy, bus.ioctl_wait} !== 2'b00) begin fails++; $display("FAIL index_ignore: busy/wait got %b want 00", {busy, bus.ioctl_wait}); end
    tests++; if (wq.size() != 0) begin fails++; $display("FAIL index_writes: got %0d writes want 0", wq.size()); end
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    send_byte(25'd3, 8'h5A, 8'd0);
    repeat (5) @(negedge clk);
    tests++; if ({err, bus.ioctl_wait} !== 2'b01) begin fails++; $display("FAIL tmo_early: err/wait got %b want 01", {err, bus.ioctl_wait}); end
    repeat (15) @(negedge clk);
    tests++; if ({err, bus.ioctl_wait, busy} !== 3'b100) begin fails++; $display("FAIL tmo_fire: err/wait/busy got %b want 100", {err, bus.ioctl_wait, busy}); end
    tests++; if (bus.sdr_req !== bus.sdr_ack) begin fails++; $display("FAIL tmo_req: req %b ack %b", bus.sdr_req, bus.sdr_ack); end
    wq.delete();
    ack_en = 1'b1;
    bus.ioctl_download = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL tmo_sticky: got %b want 1", err); end
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL tmo_clear: got %b want 0", err); end
  endtask

  task automatic test_reset_in_flight();
    ack_en = 1'b0;
    send_byte(25'd7, 8'h77, 8'd0);
    tests++; if (bus.sdr_req === bus.sdr_ack) begin fails++; $display("FAIL rif_pending: req %b equals ack %b", bus.sdr_req, bus.sdr_ack); end
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({bus.sdr_req, bus.ioctl_wait} !== 2'b00) begin fails++; $display("FAIL rif_reset: req/wait got %b want 00", {bus.sdr_req, bus.ioctl_wait}); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.sdr_req !== bus.sdr_ack) begin fails++; $display("FAIL rif_resync: req %b ack %b", bus.sdr_req, bus.sdr_ack); end
    wq.delete();
    ack_en = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    tests++; if (wq.size() != 0 || bus.sdr_req !== bus.sdr_ack) begin fails++; $display("FAIL rif_spurious: %0d writes, req %b ack %b, want 0 writes and req==ack", wq.size(), bus.sdr_req, bus.sdr_ack); end
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    test_reset();
    test_pair();
    test_odd_only();
    test_split_and_flush();
    test_other_index();
    test_timeout();
    test_reset_in_flight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
